classify_layer_seq: RTL and testbench

Time-multiplexed, parametrised successor to the combinational classify layer of the RBM datapath. It computes Output[j] = act(sum_i InputHV[i]*C_WeightI[i][j] + C_BiasI[j]) for every class j using a single multiply-accumulate unit over IN_DIM*OUT_DIM cycles, saturates each score, and reports the winning class index. It sits after the last hidden layer and drives the final decision.

---
 rtl/classify_layer_seq_pkg.sv | 48 ++++
 rtl/classify_layer_seq_mac.sv | 51 +++++
 rtl/classify_layer_seq.sv | 152 +++++++++++++++
 tb/tb_classify_layer_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/classify_layer_seq_pkg.sv
// Shared configuration for the sequential classify layer: width derivations,
// the ReLU/saturate helper, FSM state encoding and flat-vector packing macros.
`ifndef CLASSIFY_LAYER_SEQ_PKG_SV
`define CLASSIFY_LAYER_SEQ_PKG_SV

// Element idx of a flat 1D vector of w-bit elements
`define CLS_ELEM1D(vec, idx, w) vec[(idx)*(w) +: (w)]
// Element [row][col] of a flat row-major 2D vector with ncol columns
`define CLS_ELEM2D(vec, row, col, ncol, w) vec[((row)*(ncol)+(col))*(w) +: (w)]

package classify_layer_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Accumulator width: full product plus growth for IN_DIM terms plus bias
   function automatic int acc_bits(input int in_bits, input int in_dim);
      return 2*in_bits + $clog2(in_dim) + 1;
   endfunction

   function automatic int class_bits(input int out_dim);
      return $clog2(out_dim);
   endfunction

   // Optional ReLU followed by clamping to a signed out_bits range; works on
   // a 64-bit carrier so one helper serves every parameterisation
   function automatic logic signed [63:0] relu_sat(input logic signed [63:0] value,
                                                   input logic relu_en,
                                                   input int out_bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] r;
      hi = (64'sd1 <<< (out_bits-1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_bits-1));
      r  = value;
      if (relu_en && (r < 0)) r = '0;
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

`endif

// File: rtl/classify_layer_seq_mac.sv
// Single signed multiply-accumulate with the fixed-point shift, optional ReLU
// and output saturation. Sequencing is owned by the instantiating FSM.
module mac_sat_unit
   import classify_layer_seq_pkg::*;
#(
   parameter int IW        = 12,
   parameter int OW        = 8,
   parameter int ACCW      = 28,
   parameter int FRAC_BITS = 0
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          mac_en,
   input  logic          relu_en,
   input  logic [IW-1:0] bias,
   input  logic [IW-1:0] x,
   input  logic [IW-1:0] w,
   output logic [OW-1:0] score
);

   logic signed [2*IW-1:0] x_ext;
   logic signed [2*IW-1:0] w_ext;
   logic signed [2*IW-1:0] product;
   logic signed [ACCW-1:0] bias_ext;
   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] shifted;

   // Operands are widened first so the product keeps full signed precision
   assign x_ext    = {{IW{x[IW-1]}}, x};
   assign w_ext    = {{IW{w[IW-1]}}, w};
   assign product  = x_ext * w_ext;
   assign bias_ext = {{(ACCW-IW){bias[IW-1]}}, bias} <<< FRAC_BITS;

   // Accumulator: bias preload starts a column, each enabled cycle adds one term
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (load) begin
         acc <= bias_ext;
      end else if (mac_en) begin
         acc <= acc + {{(ACCW-2*IW){product[2*IW-1]}}, product};
      end
   end

   // Drop fractional bits, then ReLU/saturate into the output score width
   assign shifted = acc >>> FRAC_BITS;
   assign score   = OW'(relu_sat({{(64-ACCW){shifted[ACCW-1]}}, shifted}, relu_en, OW));

endmodule

// File: rtl/classify_layer_seq.sv
// Time-multiplexed classify layer: one MAC per cycle walks every input of
// every class, writes saturated scores column by column and reports argmax.
module classify_layer_seq
   import classify_layer_seq_pkg::*;
#(
   parameter int INPUT_BITLENGTH  = 12,
   parameter int OUTPUT_BITLENGTH = 8,
   parameter int IN_DIM           = 5,
   parameter int OUT_DIM          = 2,
   parameter int FRAC_BITS        = 0
)
(
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        start,
   input  logic                                        act_sel,
   input  logic [IN_DIM*INPUT_BITLENGTH-1:0]           InputHV,
   input  logic [IN_DIM*OUT_DIM*INPUT_BITLENGTH-1:0]   C_WeightI,
   input  logic [OUT_DIM*INPUT_BITLENGTH-1:0]          C_BiasI,
   output logic                                        busy,
   output logic                                        done,
   output logic [OUT_DIM*OUTPUT_BITLENGTH-1:0]         Output,
   output logic [class_bits(OUT_DIM)-1:0]              class_idx
);

   localparam int ACC_BITLENGTH = acc_bits(INPUT_BITLENGTH, IN_DIM);
   localparam int CLASS_BITS    = class_bits(OUT_DIM);
   localparam int IDX_BITS      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
   localparam logic [IDX_BITS-1:0]   I_LAST = IDX_BITS'(IN_DIM-1);
   localparam logic [CLASS_BITS-1:0] J_LAST = CLASS_BITS'(OUT_DIM-1);

   state_t                               state;
   state_t                               state_next;
   logic        [IDX_BITS-1:0]           i_cnt;
   logic        [CLASS_BITS-1:0]         j_cnt;
   logic        [CLASS_BITS-1:0]         bias_idx;
   logic        [CLASS_BITS-1:0]         best_idx;
   logic signed [OUTPUT_BITLENGTH-1:0]   best_score;
   logic signed [OUTPUT_BITLENGTH-1:0]   score;
   logic        [INPUT_BITLENGTH-1:0]    x_cur;
   logic        [INPUT_BITLENGTH-1:0]    w_cur;
   logic        [INPUT_BITLENGTH-1:0]    bias_cur;
   logic                                 act_q;
   logic                                 load;
   logic                                 mac_en;

   assign x_cur    = `CLS_ELEM1D(InputHV, i_cnt, INPUT_BITLENGTH);
   assign w_cur    = `CLS_ELEM2D(C_WeightI, i_cnt, j_cnt, OUT_DIM, INPUT_BITLENGTH);
   assign bias_cur = `CLS_ELEM1D(C_BiasI, bias_idx, INPUT_BITLENGTH);

   mac_sat_unit #(
      .IW        (INPUT_BITLENGTH),
      .OW        (OUTPUT_BITLENGTH),
      .ACCW      (ACC_BITLENGTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .mac_en  (mac_en),
      .relu_en (act_q),
      .bias    (bias_cur),
      .x       (x_cur),
      .w       (w_cur),
      .score   (score)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state plus MAC control; the bias for the next column is preloaded
   // during WRITE so the following MAC cycle starts from it
   always_comb begin
      state_next = state;
      load       = 1'b0;
      mac_en     = 1'b0;
      bias_idx   = '0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (i_cnt == I_LAST) state_next = WRITE;
         end
         WRITE: begin
            if (j_cnt == J_LAST) begin
               state_next = DONE;
            end else begin
               load       = 1'b1;
               bias_idx   = j_cnt + 1'b1;
               state_next = MAC;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counters, score write-back, running argmax and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_cnt      <= '0;
         j_cnt      <= '0;
         act_q      <= 1'b0;
         best_score <= '0;
         best_idx   <= '0;
         Output     <= '0;
         class_idx  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  i_cnt <= '0;
                  j_cnt <= '0;
                  act_q <= act_sel;
                  busy  <= 1'b1;
               end
            end
            MAC: begin
               if (i_cnt != I_LAST) i_cnt <= i_cnt + 1'b1;
            end
            WRITE: begin
               `CLS_ELEM1D(Output, j_cnt, OUTPUT_BITLENGTH) <= score;
               if ((j_cnt == '0) || (score > best_score)) begin
                  best_score <= score;
                  best_idx   <= j_cnt;
               end
               if (j_cnt != J_LAST) begin
                  j_cnt <= j_cnt + 1'b1;
                  i_cnt <= '0;
               end
            end
            DONE: begin
               class_idx <= best_idx;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_classify_layer_seq.sv
// Directed bench for classify_layer_seq: default configuration plus a wider
// FRAC_BITS=4 variant checked against a behavioural reference.
module tb_classify_layer_seq;

   localparam int IW  = 12;
   localparam int OW  = 8;
   localparam int ID1 = 5;
   localparam int OD1 = 2;
   localparam int ID2 = 8;
   localparam int OD2 = 10;

   logic clk;
   logic rst_n;

   // Default-parameter instance
   logic                    start;
   logic                    act_sel;
   logic [ID1*IW-1:0]       InputHV;
   logic [ID1*OD1*IW-1:0]   C_WeightI;
   logic [OD1*IW-1:0]       C_BiasI;
   logic                    busy;
   logic                    done;
   logic [OD1*OW-1:0]       Output;
   logic [0:0]              class_idx;

   // Sweep instance
   logic                    s_start;
   logic                    s_act;
   logic [ID2*IW-1:0]       s_in;
   logic [ID2*OD2*IW-1:0]   s_w;
   logic [OD2*IW-1:0]       s_b;
   logic                    s_busy;
   logic                    s_done;
   logic [OD2*OW-1:0]       s_out;
   logic [3:0]              s_class;

   int checkCount;
   int failCount;

   int xv [ID1];
   int wv [ID1][OD1];
   int bv [OD1];

   classify_layer_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .act_sel   (act_sel),
      .InputHV   (InputHV),
      .C_WeightI (C_WeightI),
      .C_BiasI   (C_BiasI),
      .busy      (busy),
      .done      (done),
      .Output    (Output),
      .class_idx (class_idx)
   );

   classify_layer_seq #(
      .INPUT_BITLENGTH  (IW),
      .OUTPUT_BITLENGTH (OW),
      .IN_DIM           (ID2),
      .OUT_DIM          (OD2),
      .FRAC_BITS        (4)
   ) dut_sweep (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (s_start),
      .act_sel   (s_act),
      .InputHV   (s_in),
      .C_WeightI (s_w),
      .C_BiasI   (s_b),
      .busy      (s_busy),
      .done      (s_done),
      .Output    (s_out),
      .class_idx (s_class)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint score8(input logic [7:0] v);
      return longint'($signed(v));
   endfunction

   task automatic checkOutput(input string tag, input longint got, input longint expected);
      checkCount++;
      if (got !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < ID1; i++) begin
         InputHV[i*IW +: IW] = xv[i][IW-1:0];
         for (int j = 0; j < OD1; j++)
            C_WeightI[(i*OD1+j)*IW +: IW] = wv[i][j][IW-1:0];
      end
      for (int j = 0; j < OD1; j++)
         C_BiasI[j*IW +: IW] = bv[j][IW-1:0];
   endtask

   task automatic setVectors(input int x0, input int xStep, input int w0, input int w1,
                             input int b0, input int b1);
      for (int i = 0; i < ID1; i++) begin
         xv[i]    = x0 + xStep*i;
         wv[i][0] = w0;
         wv[i][1] = w1;
      end
      bv[0] = b0;
      bv[1] = b1;
      applyStimulus();
   endtask

   // One start pulse, then wait for done; cyc counts edges after the accept edge
   task automatic runOne(input logic act, output int cyc, output int busyCnt);
      @(posedge clk); #1;
      start   = 1'b1;
      act_sel = act;
      @(posedge clk); #1;
      start   = 1'b0;
      act_sel = 1'b0;
      cyc     = 0;
      busyCnt = 0;
      while (!done && cyc < 40) begin
         if (busy) busyCnt++;
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("run_done_seen", longint'(done), 1);
   endtask

   // Drive start high on the listed edges and record which edges produced done
   task automatic runSchedule(input int s0, input int s1, input int s2,
                              output int nDone, output int firstDone, output int lastDone);
      nDone     = 0;
      firstDone = -1;
      lastDone  = -1;
      @(posedge clk); #1;
      for (int e = 0; e < 45; e++) begin
         start   = (e == s0) || (e == s1) || (e == s2);
         act_sel = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            nDone++;
            if (firstDone < 0) firstDone = e;
            lastDone = e;
         end
      end
      start = 1'b0;
   endtask

   task automatic checkPair(input string tag, input longint e0, input longint e1, input longint eIdx);
      checkOutput({tag, "_out0"}, score8(Output[0 +: OW]), e0);
      checkOutput({tag, "_out1"}, score8(Output[OW +: OW]), e1);
      checkOutput({tag, "_class"}, longint'(class_idx), eIdx);
   endtask

   // Random run on the sweep instance against an independent reference
   task automatic runSweep(input logic act);
      int     x2 [ID2];
      int     w2 [ID2][OD2];
      int     b2 [OD2];
      longint expS [OD2];
      longint sum;
      longint s;
      longint bestS;
      int     bestJ;
      int     cyc;
      for (int i = 0; i < ID2; i++) begin
         x2[i] = int'($urandom_range(40)) - 20;
         s_in[i*IW +: IW] = x2[i][IW-1:0];
         for (int j = 0; j < OD2; j++) begin
            w2[i][j] = int'($urandom_range(40)) - 20;
            s_w[(i*OD2+j)*IW +: IW] = w2[i][j][IW-1:0];
         end
      end
      for (int j = 0; j < OD2; j++) begin
         b2[j] = int'($urandom_range(600)) - 300;
         s_b[j*IW +: IW] = b2[j][IW-1:0];
      end
      bestS = 0;
      bestJ = 0;
      for (int j = 0; j < OD2; j++) begin
         sum = longint'(b2[j]) * 16;
         for (int i = 0; i < ID2; i++) sum += longint'(x2[i]) * longint'(w2[i][j]);
         s = sum >>> 4;
         if (act && s < 0) s = 0;
         if (s > 127)  s = 127;
         if (s < -128) s = -128;
         expS[j] = s;
         if (j == 0 || s > bestS) begin
            bestS = s;
            bestJ = j;
         end
      end
      @(posedge clk); #1;
      s_start = 1'b1;
      s_act   = act;
      @(posedge clk); #1;
      s_start = 1'b0;
      cyc = 0;
      while (!s_done && cyc < 150) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("sweep_latency", cyc, 91);
      for (int j = 0; j < OD2; j++)
         checkOutput($sformatf("sweep_out%0d", j), score8(s_out[j*OW +: OW]), expS[j]);
      checkOutput("sweep_class", longint'(s_class), bestJ);
   endtask

   initial begin
      int cyc;
      int busyCnt;
      int nDone;
      int firstDone;
      int lastDone;

      checkCount = 0;
      failCount  = 0;
      start      = 1'b0;
      act_sel    = 1'b0;
      InputHV    = '0;
      C_WeightI  = '0;
      C_BiasI    = '0;
      s_start    = 1'b0;
      s_act      = 1'b0;
      s_in       = '0;
      s_w        = '0;
      s_b        = '0;
      rst_n      = 1'b1;

      // Reset state
      #1 rst_n = 1'b0;
      #5;
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_done", longint'(done), 0);
      checkPair("reset", 0, 0, 0);
      #15 rst_n = 1'b1;

      // Basic
      setVectors(1, 1, 1, 2, 0, -5);
      runOne(1'b0, cyc, busyCnt);
      checkOutput("basic_latency", cyc, 13);
      checkOutput("basic_busy_cycles", busyCnt, 13);
      checkOutput("basic_busy_at_done", longint'(busy), 0);
      checkPair("basic", 15, 25, 1);
      @(posedge clk); #1;
      checkOutput("basic_done_pulse", longint'(done), 0);

      // Saturation
      setVectors(100, 0, 100, -100, 0, 0);
      runOne(1'b0, cyc, busyCnt);
      checkPair("sat", 127, -128, 0);

      // Linear vs ReLU on negative scores
      setVectors(7, 1, 0, 0, -20, -3);
      runOne(1'b0, cyc, busyCnt);
      checkPair("lin", -20, -3, 1);
      runOne(1'b1, cyc, busyCnt);
      checkPair("relu", 0, 0, 0);

      // Start while busy and on the DONE cycle is ignored
      setVectors(1, 1, 1, 2, 0, -5);
      runSchedule(0, 3, 13, nDone, firstDone, lastDone);
      checkOutput("ignore_done_count", nDone, 1);
      checkOutput("ignore_done_edge", firstDone, 13);
      checkPair("ignore", 15, 25, 1);

      // Earliest accepted restart gives back-to-back runs
      runSchedule(0, 14, -1, nDone, firstDone, lastDone);
      checkOutput("b2b_done_count", nDone, 2);
      checkOutput("b2b_first_done", firstDone, 13);
      checkOutput("b2b_second_done", lastDone, 27);

      // Reset mid-run aborts with no done pulse
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", longint'(busy), 0);
      checkPair("midrst", 0, 0, 0);
      #3 rst_n = 1'b1;
      nDone = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk); #1;
         if (done) nDone++;
      end
      checkOutput("midrst_no_done", nDone, 0);
      runOne(1'b0, cyc, busyCnt);
      checkOutput("rerun_latency", cyc, 13);
      checkPair("rerun", 15, 25, 1);

      // Wider configuration with fractional bits
      runSweep(1'b0);
      runSweep(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
